// File: rtl/link_order_master.sv
// Command-to-order master: buffers link-table commands in a FIFO, issues them one
// at a time to the link-table engine, and returns READ data through a response register.
module link_order_master #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned TABLE_WIDTH = 8,
    parameter int unsigned CMD_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_type,
    input  logic [TABLE_WIDTH-1:0] cmd_table,
    input  logic [ADDR_WIDTH-1:0]  cmd_node,
    input  logic [DATA_WIDTH-1:0]  cmd_data,

    output logic                   order_valid,
    input  logic                   order_busy,
    output logic [1:0]             order_type,
    output logic [TABLE_WIDTH-1:0] order_table,
    output logic [ADDR_WIDTH-1:0]  order_node,
    output logic [DATA_WIDTH-1:0]  order_data,

    input  logic                   dout_valid,
    output logic                   dout_busy,
    input  logic [DATA_WIDTH-1:0]  dout_data,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic [TABLE_WIDTH-1:0] rsp_table,
    output logic [ADDR_WIDTH-1:0]  rsp_node,
    output logic [15:0]            issued_cnt,
    output logic                   err_unexp
);

    localparam int unsigned IDX_W   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned PTR_W   = IDX_W + 1;
    localparam int unsigned ENTRY_W = 2 + TABLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [1:0]  TYPE_READ = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ENTRY_W-1:0] fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push_c;
    logic               pop_c;
    logic               accept_c;
    logic               rd_load_c;
    logic               unexp_c;

    logic [ENTRY_W-1:0]     head;
    logic [1:0]             head_type;
    logic [TABLE_WIDTH-1:0] head_table;
    logic [ADDR_WIDTH-1:0]  head_node;
    logic [DATA_WIDTH-1:0]  head_data;

    // Extra pointer bit distinguishes full (MSBs differ) from empty (equal).
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push_c     = cmd_valid && !fifo_full;
    assign dout_busy  = rsp_valid;

    assign head = fifo_mem[rd_ptr[IDX_W-1:0]];
    assign {head_type, head_table, head_node, head_data} = head;

    // FIFO storage; no reset needed since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= {cmd_type, cmd_table, cmd_node, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-edge control strobes.
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        accept_c  = 1'b0;
        rd_load_c = 1'b0;
        unexp_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!order_busy) begin
                    accept_c  = 1'b1;
                    state_nxt = (order_type == TYPE_READ) ? WAIT_RD : IDLE;
                end
            end
            WAIT_RD: begin
                if (dout_valid && !rsp_valid) begin
                    rd_load_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (state != WAIT_RD && dout_valid && !rsp_valid) begin
            unexp_c = 1'b1;
        end
    end

    // Order registers hold the fields after acceptance so a READ can tag its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            order_valid <= 1'b0;
            order_type  <= '0;
            order_table <= '0;
            order_node  <= '0;
            order_data  <= '0;
            issued_cnt  <= '0;
        end else begin
            if (pop_c) begin
                order_valid <= 1'b1;
                order_type  <= head_type;
                order_table <= head_table;
                order_node  <= head_node;
                order_data  <= head_data;
            end else if (accept_c) begin
                order_valid <= 1'b0;
            end
            if (accept_c) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
        end
    end

    // Single-entry response register; a drain edge never loads since dout_busy was high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_table <= '0;
            rsp_node  <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (rd_load_c) begin
                rsp_valid <= 1'b1;
                rsp_data  <= dout_data;
                rsp_table <= order_table;
                rsp_node  <= order_node;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (unexp_c) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_link_order_master.sv
// Scoreboard bench for link_order_master: stimulus queues expected orders/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_link_order_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [7:0]  cmd_table;
    logic [15:0] cmd_node;
    logic [15:0] cmd_data;
    logic        order_valid;
    logic        order_busy;
    logic [1:0]  order_type;
    logic [7:0]  order_table;
    logic [15:0] order_node;
    logic [15:0] order_data;
    logic        dout_valid;
    logic        dout_busy;
    logic [15:0] dout_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [7:0]  rsp_table;
    logic [15:0] rsp_node;
    logic [15:0] issued_cnt;
    logic        err_unexp;

    typedef struct packed {
        logic [1:0]  t;
        logic [7:0]  tbl;
        logic [15:0] node;
        logic [15:0] data;
    } ord_t;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  tbl;
        logic [15:0] node;
    } rsp_t;

    ord_t exp_oq[$];
    rsp_t exp_rq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    link_order_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_table(cmd_table), .cmd_node(cmd_node), .cmd_data(cmd_data),
        .order_valid(order_valid), .order_busy(order_busy), .order_type(order_type),
        .order_table(order_table), .order_node(order_node), .order_data(order_data),
        .dout_valid(dout_valid), .dout_busy(dout_busy), .dout_data(dout_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_table(rsp_table), .rsp_node(rsp_node),
        .issued_cnt(issued_cnt), .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [7:0] tbl,
                        input logic [15:0] node, input logic [15:0] data);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_table = tbl;
        cmd_node  = node;
        cmd_data  = data;
        while (!cmd_ready && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) chk("push_timeout", 64'(cmd_ready), 64'(1));
        tick();
        exp_oq.push_back('{t: t, tbl: tbl, node: node, data: data});
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issued(input logic [15:0] target);
        int g = 0;
        while (issued_cnt != target && g < 100) begin
            tick();
            g++;
        end
        chk("wait_issued", 64'(issued_cnt), 64'(target));
    endtask

    // Monitor: orders compared every cycle they are presented, popped at acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            if (order_valid) begin
                if (exp_oq.size() == 0) begin
                    chk("order_unexpected", 64'(order_valid), 64'(0));
                end else begin
                    chk("order_fields", 64'({order_type, order_table, order_node, order_data}),
                        64'(exp_oq[0]));
                    if (!order_busy) void'(exp_oq.pop_front());
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rq.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    chk("rsp_fields", 64'({rsp_data, rsp_table, rsp_node}), 64'(exp_rq[0]));
                    void'(exp_rq.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_table = '0; cmd_node = '0;
        cmd_data = '0; order_busy = 1'b0; dout_valid = 1'b0; dout_data = '0; rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_order_valid", 64'(order_valid), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_issued_cnt", 64'(issued_cnt), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        rst = 1'b0;
        tick();

        // Single APPE, engine idle: one cycle of order_valid.
        push(2'b00, 8'd3, 16'd1, 16'd111);
        chk("t1_latency_low", 64'(order_valid), 64'(0));
        tick();
        chk("t1_order_valid", 64'(order_valid), 64'(1));
        tick();
        chk("t1_order_drop", 64'(order_valid), 64'(0));
        chk("t1_issued", 64'(issued_cnt), 64'(1));

        // Engine busy for 3 cycles: fields stable, single increment.
        order_busy = 1'b1;
        push(2'b00, 8'd3, 16'd2, 16'd112);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_valid", 64'(order_valid), 64'(1));
            chk("t2_hold_cnt", 64'(issued_cnt), 64'(1));
            if (i < 2) tick();
        end
        order_busy = 1'b0;
        tick();
        chk("t2_issued", 64'(issued_cnt), 64'(2));
        chk("t2_order_drop", 64'(order_valid), 64'(0));

        // Five back-to-back pushes against a busy engine fill FIFO + ISSUE slot.
        tick();
        order_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(2'b10, 8'(i + 1), 16'(16'h100 + i), 16'(16'h200 + i));
        end
        chk("t3_full", 64'(cmd_ready), 64'(0));
        order_busy = 1'b0;
        wait_issued(16'd7);
        tick();
        chk("t3_drained", 64'(exp_oq.size()), 64'(0));
        chk("t3_ready", 64'(cmd_ready), 64'(1));

        // READ then APPE: APPE must wait for readback.
        exp_rq.push_back('{data: 16'd112, tbl: 8'd3, node: 16'd2});
        push(2'b11, 8'd3, 16'd2, 16'd0);
        push(2'b00, 8'd1, 16'd3, 16'd20);
        wait_issued(16'd8);
        tick();
        tick();
        chk("t4_wait_no_order", 64'(order_valid), 64'(0));
        chk("t4_wait_cnt", 64'(issued_cnt), 64'(8));
        dout_valid = 1'b1;
        dout_data  = 16'd112;
        tick();
        dout_valid = 1'b0;
        chk("t4_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("t4_rsp_data", 64'(rsp_data), 64'(112));
        wait_issued(16'd9);
        chk("t4_no_err", 64'(err_unexp), 64'(0));
        tick();

        // Response held: second readback stalls on dout_busy until drained.
        rsp_ready = 1'b0;
        exp_rq.push_back('{data: 16'h0055, tbl: 8'd5, node: 16'd9});
        exp_rq.push_back('{data: 16'h0066, tbl: 8'd6, node: 16'd7});
        push(2'b11, 8'd5, 16'd9, 16'd0);
        wait_issued(16'd10);
        dout_valid = 1'b1;
        dout_data  = 16'h0055;
        tick();
        dout_valid = 1'b0;
        chk("t5_busy1", 64'(dout_busy), 64'(1));
        push(2'b11, 8'd6, 16'd7, 16'd0);
        wait_issued(16'd11);
        dout_valid = 1'b1;
        dout_data  = 16'h0066;
        tick();
        tick();
        chk("t5_stall_busy", 64'(dout_busy), 64'(1));
        chk("t5_stall_data", 64'(rsp_data), 64'(16'h0055));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t5_drain_no_load", 64'(rsp_valid), 64'(0));
        tick();
        dout_valid = 1'b0;
        chk("t5_second_valid", 64'(rsp_valid), 64'(1));
        chk("t5_second_data", 64'(rsp_data), 64'(16'h0066));
        rsp_ready = 1'b1;
        tick();
        chk("t5_second_drain", 64'(rsp_valid), 64'(0));
        chk("t5_no_err", 64'(err_unexp), 64'(0));

        // Unexpected readback in IDLE is sticky.
        dout_valid = 1'b1;
        dout_data  = 16'hdead;
        tick();
        dout_valid = 1'b0;
        chk("t6_err_set", 64'(err_unexp), 64'(1));
        chk("t6_discard", 64'(rsp_valid), 64'(0));
        tick();
        chk("t6_err_sticky", 64'(err_unexp), 64'(1));

        // Reset while in WAIT_RD abandons the read.
        push(2'b11, 8'd2, 16'd4, 16'd0);
        wait_issued(16'd12);
        rst = 1'b1;
        tick();
        chk("t7_order_valid", 64'(order_valid), 64'(0));
        chk("t7_order_fields", 64'({order_type, order_table, order_node, order_data}), 64'(0));
        chk("t7_rsp", 64'({rsp_valid, dout_busy, rsp_data, rsp_table, rsp_node}), 64'(0));
        chk("t7_err", 64'(err_unexp), 64'(0));
        chk("t7_issued", 64'(issued_cnt), 64'(0));
        rst = 1'b0;
        chk("t7_cmd_ready", 64'(cmd_ready), 64'(1));
        tick();
        dout_valid = 1'b1;
        dout_data  = 16'h0077;
        tick();
        dout_valid = 1'b0;
        chk("t7_late_readback_err", 64'(err_unexp), 64'(1));
        chk("t7_late_no_rsp", 64'(rsp_valid), 64'(0));
        tick();

        chk("end_orders_left", 64'(exp_oq.size()), 64'(0));
        chk("end_rsps_left", 64'(exp_rq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
